// File: rtl/niosii_system_nios2_0_oci_dct_packer_if.sv
// rtl/niosii_system_nios2_0_oci_dct_packer_if.sv - trace frame input and packed DCT word output streams
interface niosii_system_nios2_0_oci_dct_packer_if #(
    parameter int FRAME_W = 2,
    parameter int FRAMES  = 15,
    parameter int CNT_W   = $clog2(FRAMES + 1)
);
    logic                        frame_valid;
    logic [FRAME_W-1:0]          frame_data;
    logic                        dct_ready;
    logic                        dct_valid;
    logic [FRAME_W*FRAMES-1:0]   dct_buffer;
    logic [CNT_W-1:0]            dct_count;

    modport master (
        output frame_valid, frame_data, dct_ready,
        input  dct_valid, dct_buffer, dct_count
    );

    modport slave (
        input  frame_valid, frame_data, dct_ready,
        output dct_valid, dct_buffer, dct_count
    );
endinterface

// File: rtl/niosii_system_nios2_0_oci_dct_packer.sv
// rtl/niosii_system_nios2_0_oci_dct_packer.sv - packs trace frames into DCT words; OCI_DCT_PACKER_STATS_EN adds drop counter
module niosii_system_nios2_0_oci_dct_packer #(
    parameter int FRAME_W = 2,
    parameter int FRAMES  = 15,
    parameter int CNT_W   = $clog2(FRAMES + 1)
) (
    input  logic        clk,
    input  logic        reset_n,
    niosii_system_nios2_0_oci_dct_packer_if.slave bus,
    input  logic        test_ending,
    output logic        overflow,
    output logic        test_has_ended,
    output logic [15:0] drop_count
);
    localparam int BUF_W = FRAME_W * FRAMES;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FRAMES);

    typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

    state_t             state, state_next;
    logic [BUF_W-1:0]   acc, acc_next;
    logic [CNT_W-1:0]   acc_cnt, acc_cnt_next;
    logic [CNT_W-1:0]   wr_slot;
    logic               slot_free, transfer, accept, drop;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= RUN;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        slot_free  = !bus.dct_valid || bus.dct_ready;
        transfer   = slot_free && ((acc_cnt == FULL) || (state == FLUSH && acc_cnt != '0));
        accept     = 1'b0;
        drop       = 1'b0;
        if (state == RUN && bus.frame_valid) begin
            if (acc_cnt < FULL || transfer) accept = 1'b1;
            else                            drop   = 1'b1;
        end
        case (state)
            RUN:     if (test_ending) state_next = FLUSH;
            // The last word may leave this very cycle, so DONE follows it without a gap.
            FLUSH:   if (acc_cnt == '0 && slot_free) state_next = DONE;
            DONE:    state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        acc_next     = acc;
        acc_cnt_next = acc_cnt;
        wr_slot      = transfer ? '0 : acc_cnt;
        if (transfer) begin
            acc_next     = '0;
            acc_cnt_next = '0;
        end
        if (accept) begin
            for (int i = 0; i < FRAMES; i++) begin
                if (CNT_W'(i) == wr_slot) acc_next[i*FRAME_W +: FRAME_W] = bus.frame_data;
            end
            acc_cnt_next = wr_slot + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc            <= '0;
            acc_cnt        <= '0;
            bus.dct_valid  <= 1'b0;
            bus.dct_buffer <= '0;
            bus.dct_count  <= '0;
            overflow       <= 1'b0;
        end else begin
            acc     <= acc_next;
            acc_cnt <= acc_cnt_next;
            if (transfer) begin
                bus.dct_valid  <= 1'b1;
                bus.dct_buffer <= acc;
                bus.dct_count  <= acc_cnt;
            end else if (bus.dct_ready) begin
                bus.dct_valid  <= 1'b0;
            end
            if (drop) overflow <= 1'b1;
        end
    end

`ifdef OCI_DCT_PACKER_STATS_EN
    logic [15:0] drops;

    always_ff @(posedge clk) begin
        if (!reset_n)                    drops <= '0;
        else if (drop && drops != 16'hFFFF) drops <= drops + 16'd1;
    end

    assign drop_count = drops;
`else
    assign drop_count = '0;
`endif

    assign test_has_ended = (state == DONE);
endmodule

// File: tb/tb_niosii_system_nios2_0_oci_dct_packer.sv
// tb/tb_niosii_system_nios2_0_oci_dct_packer.sv - randomized bench with queue-based reference model for the DCT packer
module tb_niosii_system_nios2_0_oci_dct_packer;
    localparam int FRAME_W = 2;
    localparam int FRAMES  = 15;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        test_ending;
    logic        overflow;
    logic        test_has_ended;
    logic [15:0] drop_count;

    niosii_system_nios2_0_oci_dct_packer_if #(.FRAME_W(FRAME_W), .FRAMES(FRAMES)) bus ();

    niosii_system_nios2_0_oci_dct_packer #(.FRAME_W(FRAME_W), .FRAMES(FRAMES)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .bus            (bus),
        .test_ending    (test_ending),
        .overflow       (overflow),
        .test_has_ended (test_has_ended),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: frames waiting to be packed, plus the word on offer.
    int          m_frames[$];
    logic        m_valid;
    logic [63:0] m_word;
    int          m_cnt;
    logic        m_ovf;
    int          m_drops;
    int          m_phase;   // 0 running, 1 draining, 2 finished pulse

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_frames.delete();
        m_valid = 1'b0;
        m_word  = '0;
        m_cnt   = 0;
        m_ovf   = 1'b0;
        m_drops = 0;
        m_phase = 0;
    endtask

    task automatic model_update();
        int   held;
        logic room, send;
        if (!reset_n) begin
            model_clear();
            return;
        end
        held = m_frames.size();
        room = !m_valid || bus.dct_ready;
        send = room && (held == FRAMES || (m_phase == 1 && held > 0));
        if (send) begin
            m_word = '0;
            for (int i = 0; i < held; i++)
                m_word = m_word + 64'(m_frames[i]) * (64'd1 << (i * FRAME_W));
            m_cnt   = held;
            m_valid = 1'b1;
            m_frames.delete();
        end else if (bus.dct_ready) begin
            m_valid = 1'b0;
        end
        if (m_phase == 0 && bus.frame_valid) begin
            if (held < FRAMES || send) m_frames.push_back(int'(bus.frame_data));
            else begin
                m_ovf = 1'b1;
                if (m_drops < 65535) m_drops++;
            end
        end
        case (m_phase)
            0: if (test_ending) m_phase = 1;
            1: if (held == 0 && room) m_phase = 2;
            default: m_phase = 0;
        endcase
    endtask

    task automatic compare_all();
        check("dct_valid", 64'(bus.dct_valid), 64'(m_valid));
        check("dct_buffer", 64'(bus.dct_buffer), m_word);
        check("dct_count", 64'(bus.dct_count), 64'(m_cnt));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("test_has_ended", 64'(test_has_ended), 64'(m_phase == 2));
`ifdef OCI_DCT_PACKER_STATS_EN
        check("drop_count", 64'(drop_count), 64'(m_drops));
`else
        check("drop_count", 64'(drop_count), 64'd0);
`endif
    endtask

    task automatic step(input logic fv, input logic [1:0] fd, input logic te,
                        input logic rdy, input logic rst_n);
        bus.frame_valid = fv;
        bus.frame_data  = fd;
        test_ending     = te;
        bus.dct_ready   = rdy;
        reset_n         = rst_n;
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    int words;

    initial begin
        model_clear();
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        // Fifteen frames of 01 form one full word
        for (int k = 0; k < 15; k++) step(1, 2'b01, 0, 1, 1);
        check("t1_valid_early", 64'(bus.dct_valid), 64'd0);
        step(0, 0, 0, 1, 1);
        check("t1_valid", 64'(bus.dct_valid), 64'd1);
        check("t1_buffer", 64'(bus.dct_buffer), 64'h15555555);
        check("t1_count", 64'(bus.dct_count), 64'd15);
        step(0, 0, 0, 1, 1);

        // Stalled output: 31st frame is dropped
        for (int k = 0; k < 31; k++) step(1, 2'($urandom_range(0, 3)), 0, 0, 1);
        check("t2_overflow", 64'(overflow), 64'd1);
`ifdef OCI_DCT_PACKER_STATS_EN
        check("t2_drops", 64'(drop_count), 64'd1);
`else
        check("t2_drops", 64'(drop_count), 64'd0);
`endif
        for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);

        // Partial word flush
        for (int k = 0; k < 5; k++) step(1, 2'b11, 0, 1, 1);
        step(0, 0, 1, 1, 1);
        step(0, 0, 0, 1, 1);
        check("t3_valid", 64'(bus.dct_valid), 64'd1);
        check("t3_buffer", 64'(bus.dct_buffer), 64'h3FF);
        check("t3_count", 64'(bus.dct_count), 64'd5);
        check("t3_not_ended", 64'(test_has_ended), 64'd0);
        step(0, 0, 0, 1, 1);
        check("t3_ended", 64'(test_has_ended), 64'd1);
        step(0, 0, 0, 1, 1);
        check("t3_pulse_end", 64'(test_has_ended), 64'd0);

        // Empty flush
        step(0, 0, 1, 1, 1);
        check("t4_c1", 64'(test_has_ended), 64'd0);
        step(0, 0, 0, 1, 1);
        check("t4_c2", 64'(test_has_ended), 64'd1);
        check("t4_valid", 64'(bus.dct_valid), 64'd0);
        step(0, 0, 0, 1, 1);
        check("t4_c3", 64'(test_has_ended), 64'd0);

        // 45 continuous frames -> three words, no drops
        words = 0;
        for (int k = 0; k < 48; k++) begin
            step(k < 45, 2'($urandom_range(0, 3)), 0, 1, 1);
            if (bus.dct_valid) words++;
        end
        check("t5_words", 64'(words), 64'd3);
        check("t5_overflow", 64'(overflow), 64'd0);

        // Reset with a word held and seven frames buffered
        for (int k = 0; k < 22; k++) step(1, 2'($urandom_range(0, 3)), 0, 0, 1);
        check("t6_held", 64'(bus.dct_valid), 64'd1);
        step(0, 0, 0, 0, 0);
        check("t6_rst_valid", 64'(bus.dct_valid), 64'd0);
        check("t6_rst_buffer", 64'(bus.dct_buffer), 64'd0);
        for (int k = 0; k < 15; k++) step(1, 2'b10, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        check("t6_buffer", 64'(bus.dct_buffer), 64'h2AAAAAAA);
        check("t6_count", 64'(bus.dct_count), 64'd15);

        // Random traffic
        for (int k = 0; k < 800; k++) begin
            step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 299) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
